// File: rtl/sonic_addr_pkg.sv
// Shared types for the sonic address generator / converter pair.
package sonic_addr_pkg;

  localparam int SONIC_ADDR_WIDTH = 13;
  localparam int SONIC_LEN_WIDTH  = 13;

  typedef logic [SONIC_ADDR_WIDTH-1:0] sonic_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_e;

endpackage

// File: rtl/sonic_address_generator_if.sv
// Command and address-stream handshake bundle; cmd_stride exists only when
// SONIC_ADDR_GEN_STRIDE_EN is defined.
interface sonic_address_generator_if
  import sonic_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = SONIC_ADDR_WIDTH,
  parameter int LEN_WIDTH  = SONIC_LEN_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef SONIC_ADDR_GEN_STRIDE_EN
  logic [ADDR_WIDTH-1:0] cmd_stride;
`endif
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_last;

  // master: the generator side (accepts commands, drives the address stream)
  modport master (
`ifdef SONIC_ADDR_GEN_STRIDE_EN
    input  cmd_stride,
`endif
    input  cmd_valid, cmd_base, cmd_len, addr_ready,
    output cmd_ready, addr_valid, addr, addr_last
  );

  modport slave (
`ifdef SONIC_ADDR_GEN_STRIDE_EN
    output cmd_stride,
`endif
    output cmd_valid, cmd_base, cmd_len, addr_ready,
    input  cmd_ready, addr_valid, addr, addr_last
  );
endinterface

// File: rtl/sonic_ring_incr.sv
// Combinational next address in a ring of RING_DEPTH words (any depth 2..2**ADDR_WIDTH).
module sonic_ring_incr #(
  parameter int ADDR_WIDTH = 13,
  parameter int RING_DEPTH = 8192
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RING_DEPTH);

  logic [ADDR_WIDTH:0] sum;
  logic [ADDR_WIDTH:0] wrapped;

  // One extra bit so addr+stride never overflows before the wrap compare.
  assign sum       = {1'b0, addr} + {1'b0, stride};
  assign wrapped   = (sum >= DEPTH) ? (sum - DEPTH) : sum;
  assign next_addr = wrapped[ADDR_WIDTH-1:0];
endmodule

// File: rtl/sonic_address_generator.sv
// Turns (base, len) commands into a stream of ring-buffer word addresses.
// Optional per-command stride when SONIC_ADDR_GEN_STRIDE_EN is defined.
module sonic_address_generator
  import sonic_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = SONIC_ADDR_WIDTH,
  parameter int LEN_WIDTH  = SONIC_LEN_WIDTH,
  parameter int RING_DEPTH = 8192
) (
  input  logic                         clk,
  input  logic                         rst,
  sonic_address_generator_if.master    bus,
  output logic                         done,
  output logic                         err,
  output logic                         busy
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RING_DEPTH);

  gen_state_e            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  base_bad;
  logic                  stride_bad;

  assign base_bad = ({1'b0, bus.cmd_base} >= DEPTH);

`ifdef SONIC_ADDR_GEN_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign step       = stride_q;
  assign stride_bad = ({1'b0, bus.cmd_stride} > DEPTH);
`else
  assign step       = ADDR_WIDTH'(1);
  assign stride_bad = 1'b0;
`endif

  sonic_ring_incr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RING_DEPTH (RING_DEPTH)
  ) u_incr (
    .addr      (addr_q),
    .stride    (step),
    .next_addr (next_addr)
  );

  // Both decode a single state flop, so they are glitch-free registered outputs.
  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);
  assign bus.addr      = addr_q;

  // NOTE: all state uses non-blocking assignments and a synchronous reset
  // tested first, so every flop sees the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      remaining      <= '0;
      bus.addr_valid <= 1'b0;
      bus.addr_last  <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef SONIC_ADDR_GEN_STRIDE_EN
      stride_q       <= ADDR_WIDTH'(1);
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (base_bad || stride_bad) begin
              err <= 1'b1;
            end else if (bus.cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state          <= RUN;
              addr_q         <= bus.cmd_base;
              remaining      <= bus.cmd_len;
              bus.addr_valid <= 1'b1;
              bus.addr_last  <= (bus.cmd_len == LEN_WIDTH'(1));
`ifdef SONIC_ADDR_GEN_STRIDE_EN
              stride_q       <= (bus.cmd_stride == '0) ? ADDR_WIDTH'(1) : bus.cmd_stride;
`endif
            end
          end
        end
        RUN: begin
          // addr_valid is always high in RUN, so addr_ready alone marks a handshake.
          if (bus.addr_ready) begin
            if (remaining == LEN_WIDTH'(1)) begin
              state          <= IDLE;
              remaining      <= '0;
              bus.addr_valid <= 1'b0;
              bus.addr_last  <= 1'b0;
              done           <= 1'b1;
            end else begin
              addr_q        <= next_addr;
              remaining     <= remaining - LEN_WIDTH'(1);
              bus.addr_last <= (remaining == LEN_WIDTH'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sonic_address_generator.sv
// Directed bench: cycle-by-cycle vector table on a RING_DEPTH=1000 instance,
// plus hand sequences for the 8192-word wrap and (when enabled) stride.
module tb_sonic_address_generator;
  import sonic_addr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic done, err, busy;
  logic f_done, f_err, f_busy;

  sonic_address_generator_if #(.ADDR_WIDTH(13), .LEN_WIDTH(13)) bus ();
  sonic_address_generator_if #(.ADDR_WIDTH(13), .LEN_WIDTH(13)) fbus ();

  sonic_address_generator #(.ADDR_WIDTH(13), .LEN_WIDTH(13), .RING_DEPTH(1000)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .done (done),
    .err  (err),
    .busy (busy)
  );

  sonic_address_generator #(.ADDR_WIDTH(13), .LEN_WIDTH(13), .RING_DEPTH(8192)) u_full (
    .clk  (clk),
    .rst  (rst),
    .bus  (fbus),
    .done (f_done),
    .err  (f_err),
    .busy (f_busy)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [12:0] base;
    logic [12:0] len;
    logic        ready;
    logic [18:0] exp;  // {cmd_ready, addr_valid, addr, addr_last, done, err, busy}
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [18:0] pk(logic cr, logic av, int a, logic al,
                                     logic d, logic e, logic bz);
    return {cr, av, 13'(a), al, d, e, bz};
  endfunction

  function automatic void add(logic r, logic v, int b, int l, logic rd,
                              logic [18:0] e);
    vec_t t;
    t.rst = r; t.valid = v; t.base = 13'(b); t.len = 13'(l); t.ready = rd; t.exp = e;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //   rst v  base   len rdy      cr av addr   al d  e  bz
    add(1, 0, 0,     0,  1, pk(1, 0, 0,     0, 0, 0, 0));  // reset state
    add(0, 1, 'h010, 4,  1, pk(0, 1, 'h010, 0, 0, 0, 1));  // basic
    add(0, 0, 0,     0,  1, pk(0, 1, 'h011, 0, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(0, 1, 'h012, 0, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(0, 1, 'h013, 1, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(1, 0, 'h013, 0, 1, 0, 0));
    add(0, 0, 0,     0,  1, pk(1, 0, 'h013, 0, 0, 0, 0));
    add(0, 1, 'h100, 3,  0, pk(0, 1, 'h100, 0, 0, 0, 1));  // backpressure
    add(0, 1, 'h200, 5,  0, pk(0, 1, 'h100, 0, 0, 0, 1));  // cmd ignored in RUN
    add(0, 0, 0,     0,  0, pk(0, 1, 'h100, 0, 0, 0, 1));
    add(0, 0, 0,     0,  0, pk(0, 1, 'h100, 0, 0, 0, 1));
    add(0, 0, 0,     0,  0, pk(0, 1, 'h100, 0, 0, 0, 1));
    add(0, 0, 0,     0,  0, pk(0, 1, 'h100, 0, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(0, 1, 'h101, 0, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(0, 1, 'h102, 1, 0, 0, 1));
    add(0, 0, 0,     0,  0, pk(0, 1, 'h102, 1, 0, 0, 1));  // stall on last
    add(0, 0, 0,     0,  1, pk(1, 0, 'h102, 0, 1, 0, 0));
    add(0, 1, 'h055, 0,  1, pk(1, 0, 'h102, 0, 1, 0, 0));  // len = 0
    add(0, 0, 0,     0,  1, pk(1, 0, 'h102, 0, 0, 0, 0));
    add(0, 1, 1000,  5,  1, pk(1, 0, 'h102, 0, 0, 1, 0));  // base = RING_DEPTH
    add(0, 0, 0,     0,  1, pk(1, 0, 'h102, 0, 0, 0, 0));
    add(0, 1, 999,   2,  1, pk(0, 1, 999,   0, 0, 0, 1));  // base = RING_DEPTH-1
    add(0, 0, 0,     0,  1, pk(0, 1, 0,     1, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(1, 0, 0,     0, 1, 0, 0));
    add(0, 1, 5,     1,  1, pk(0, 1, 5,     1, 0, 0, 1));  // accepted right after done
    add(0, 0, 0,     0,  1, pk(1, 0, 5,     0, 1, 0, 0));
    add(0, 1, 'h020, 10, 1, pk(0, 1, 'h020, 0, 0, 0, 1));  // reset mid-run
    add(0, 0, 0,     0,  1, pk(0, 1, 'h021, 0, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(0, 1, 'h022, 0, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(0, 1, 'h023, 0, 0, 0, 1));
    add(1, 0, 0,     0,  1, pk(1, 0, 0,     0, 0, 0, 0));
    add(0, 1, 'h040, 1,  0, pk(0, 1, 'h040, 1, 0, 0, 1));
    add(0, 0, 0,     0,  0, pk(0, 1, 'h040, 1, 0, 0, 1));
    add(0, 0, 0,     0,  1, pk(1, 0, 'h040, 0, 1, 0, 0));
    add(0, 0, 0,     0,  1, pk(1, 0, 'h040, 0, 0, 0, 0));

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0; bus.addr_ready = 1'b1;
    fbus.cmd_valid = 1'b0; fbus.cmd_base = '0; fbus.cmd_len = '0; fbus.addr_ready = 1'b1;
`ifdef SONIC_ADDR_GEN_STRIDE_EN
    bus.cmd_stride  = '0;  // zero stride behaves as 1 throughout the table
    fbus.cmd_stride = 13'd1;
`endif
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      bus.cmd_valid  = vecs[i].valid;
      bus.cmd_base   = vecs[i].base;
      bus.cmd_len    = vecs[i].len;
      bus.addr_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d {cr,av,addr,last,done,err,busy}", i),
            32'({bus.cmd_ready, bus.addr_valid, bus.addr, bus.addr_last, done, err, busy}),
            32'(vecs[i].exp));
    end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;

    // Full 8192-word ring: 0x1FFE, 0x1FFF, 0x0000, 0x0001 then done.
    fbus.cmd_valid = 1'b1; fbus.cmd_base = 13'h1FFE; fbus.cmd_len = 13'd4;
    fbus.addr_ready = 1'b1;
    tick();
    fbus.cmd_valid = 1'b0;
    check("wrap8192 a0", 32'({fbus.addr_valid, fbus.addr, fbus.addr_last}), 32'({1'b1, 13'h1FFE, 1'b0}));
    tick();
    check("wrap8192 a1", 32'({fbus.addr_valid, fbus.addr, fbus.addr_last}), 32'({1'b1, 13'h1FFF, 1'b0}));
    tick();
    check("wrap8192 a2", 32'({fbus.addr_valid, fbus.addr, fbus.addr_last}), 32'({1'b1, 13'h0000, 1'b0}));
    tick();
    check("wrap8192 a3", 32'({fbus.addr_valid, fbus.addr, fbus.addr_last}), 32'({1'b1, 13'h0001, 1'b1}));
    tick();
    check("wrap8192 done", 32'({fbus.addr_valid, f_done, f_busy, fbus.cmd_ready}), 32'(4'b0101));

`ifdef SONIC_ADDR_GEN_STRIDE_EN
    // Stride 7 in a 1000-word ring: 990, 997, 4.
    bus.cmd_valid = 1'b1; bus.cmd_base = 13'd990; bus.cmd_len = 13'd3;
    bus.cmd_stride = 13'd7; bus.addr_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("stride a0", 32'({bus.addr_valid, bus.addr, bus.addr_last}), 32'({1'b1, 13'd990, 1'b0}));
    tick();
    check("stride a1", 32'({bus.addr_valid, bus.addr, bus.addr_last}), 32'({1'b1, 13'd997, 1'b0}));
    tick();
    check("stride a2", 32'({bus.addr_valid, bus.addr, bus.addr_last}), 32'({1'b1, 13'd4, 1'b1}));
    tick();
    check("stride done", 32'({bus.addr_valid, done, err}), 32'(3'b010));

    // Stride larger than the ring is rejected.
    bus.cmd_valid = 1'b1; bus.cmd_base = 13'd0; bus.cmd_len = 13'd2; bus.cmd_stride = 13'd1001;
    tick();
    bus.cmd_valid = 1'b0;
    check("stride too big", 32'({bus.addr_valid, done, err, bus.cmd_ready}), 32'(4'b0011));
    tick();
    check("stride err pulse", 32'({err, busy}), 32'(2'b00));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
